// File: rtl/mult_share_pkg.sv
// Shared definitions for the mult_share_arb slice: FSM encoding, default sizes
// and the clog2 helper used to size requester IDs.
package mult_share_pkg;

  localparam int DEF_W    = 3;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Returns ceil(log2(n)), but never less than 1 so a lone requester still has an ID bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/response bundle of mult_share_arb.
// master = requesters plus response consumer; slave = the arbiter.
interface mult_share_arb_if
  import mult_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
);
  localparam int IDW = clog2_min1(NREQ);

  // Valid/ready: a beat moves on any rising edge where valid && ready are both 1.
  // The source holds its payload while valid is high; on the request side valid
  // may also be withdrawn before acceptance without consequence.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/mult_share_arb_multiplier.sv
// Combinational unsigned W x W multiplier with full 2*W-bit product.
module multiplier #(
  parameter int W = 3
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters.
// Define MULT_SHARE_ARB_BYPASS_EN to skip CALC and register the product at accept.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  mult_share_arb_if.slave   bus,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int IDW = clog2_min1(NREQ);

  state_t           state, state_nxt;
  logic [IDW-1:0]   last_id;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             accept;
  int               idx;
  logic [W-1:0]     sel_a, sel_b;
  logic [W-1:0]     op_a, op_b;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     mult_a, mult_b;
  logic [2*W-1:0]   prod;
  logic [2*W-1:0]   rsp_p_q;
  logic [IDW-1:0]   rsp_id_q;

  // Search starts one past the last winner and wraps, so priority rotates.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_id) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
      end
    end
  end

  assign accept        = (state == ST_IDLE) && found && !rst;
  assign bus.req_ready = accept ? (NREQ'(1) << winner) : '0;

`ifdef MULT_SHARE_ARB_BYPASS_EN
  assign mult_a = sel_a;
  assign mult_b = sel_b;
`else
  assign mult_a = op_a;
  assign mult_b = op_b;
`endif

  multiplier #(.W(W)) u_mult (
    .a (mult_a),
    .b (mult_b),
    .p (prod)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
`ifdef MULT_SHARE_ARB_BYPASS_EN
        if (accept) state_nxt = ST_RESP;
`else
        if (accept) state_nxt = ST_CALC;
`endif
      end
      ST_CALC: state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_id  <= IDW'(NREQ - 1);
      op_a     <= '0;
      op_b     <= '0;
      id_q     <= '0;
      rsp_p_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_id <= winner;
        op_a    <= sel_a;
        op_b    <= sel_b;
        id_q    <= winner;
`ifdef MULT_SHARE_ARB_BYPASS_EN
        rsp_p_q  <= prod;
        rsp_id_q <= winner;
`endif
      end
`ifndef MULT_SHARE_ARB_BYPASS_EN
      if (state == ST_CALC) begin
        rsp_p_q  <= prod;
        rsp_id_q <= id_q;
      end
`endif
    end
  end

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_p     = rsp_p_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb (NREQ=4, W=3): reset, single request,
// round-robin fairness, backpressure, corner operands and reset mid-operation.
module tb_mult_share_arb;
  import mult_share_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 3;
`ifdef MULT_SHARE_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic   clk;
  logic   rst;
  logic   busy;
  state_t dbg_state;
  int     n_tests;
  int     n_fail;
  logic [7:0] exp_q[$];

  mult_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic set_op(input int id, input int a, input int b);
    bus.req_a[id*W +: W] = W'(a);
    bus.req_b[id*W +: W] = W'(b);
  endtask

  task automatic wait_rsp(output bit ok, output int cycles);
    cycles = 0;
    while (!bus.rsp_valid && cycles < 20) begin
      step();
      cycles++;
    end
    ok = bus.rsp_valid;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'hF;
    bus.req_a     = '1;
    bus.req_b     = '1;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready);
    end
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state got valid=%b busy=%b st=%0d exp 0 0 0",
                         bus.rsp_valid, busy, dbg_state);
    end
    n_tests++;
    if (bus.rsp_p !== 6'd0 || bus.rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_rsp got p=%0d id=%0d exp 0 0", bus.rsp_p, bus.rsp_id);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    bit ok;
    int cyc;
    bus.req_a = '0;
    bus.req_b = '0;
    set_op(0, 1, 2);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready);
    end
    step();
    n_tests++;
    if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_pulse got ready=%b busy=%b exp 0000 1", bus.req_ready, busy);
    end
    bus.req_valid = '0;
    wait_rsp(ok, cyc);
    n_tests++;
    if (!ok || (1 + cyc) !== LAT) begin
      n_fail++; $display("FAIL single_latency got ok=%0d lat=%0d exp lat=%0d", ok, 1 + cyc, LAT);
    end
    n_tests++;
    if (bus.rsp_p !== 6'b000010 || bus.rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL single_rsp got p=%0d id=%0d exp 2 0", bus.rsp_p, bus.rsp_id);
    end
    step();
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL single_done got valid=%b st=%0d exp 0 0", bus.rsp_valid, dbg_state);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int cyc;
    logic [7:0] exp;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 3);
    exp_q.push_back({2'd0, 6'd3});
    exp_q.push_back({2'd1, 6'd6});
    exp_q.push_back({2'd2, 6'd9});
    exp_q.push_back({2'd3, 6'd12});
    exp_q.push_back({2'd0, 6'd3});
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(ok, cyc);
      exp = exp_q.pop_front();
      n_tests++;
      if (!ok || cyc !== LAT) begin
        n_fail++; $display("FAIL fair_spacing[%0d] got ok=%0d cyc=%0d exp %0d", n, ok, cyc, LAT);
      end
      n_tests++;
      if ({bus.rsp_id, bus.rsp_p} !== exp) begin
        n_fail++; $display("FAIL fair_rsp[%0d] got id=%0d p=%0d exp id=%0d p=%0d",
                           n, bus.rsp_id, bus.rsp_p, exp[7:6], exp[5:0]);
      end
      step();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    set_op(2, 5, 6);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'hF;
    set_op(2, 7, 7);
    wait_rsp(ok, cyc);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_rsp_timeout got valid=0 exp valid=1");
    end
    for (int n = 0; n < 5; n++) begin
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 6'd30 || bus.rsp_id !== 2'd2 ||
          bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b p=%0d id=%0d rdy=%b exp 1 30 2 0000",
                           n, bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.req_ready);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_no_accept_on_complete got=%b exp=0000", bus.req_ready);
    end
    step();
    n_tests++;
    if (dbg_state !== ST_IDLE || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_release got st=%0d v=%b rdy=%b exp 0 0 1000",
                         dbg_state, bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_corner();
    int ids[3]  = '{3, 1, 0};
    int as[3]   = '{7, 0, 3};
    int bs[3]   = '{7, 5, 5};
    int exps[3] = '{49, 0, 15};
    bit ok;
    int cyc;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_op(ids[n], as[n], bs[n]);
      bus.req_valid = 4'(1 << ids[n]);
      #1;
      n_tests++;
      if (bus.req_ready !== 4'(1 << ids[n])) begin
        n_fail++; $display("FAIL corner_ready[%0d] got=%b exp=%b", n, bus.req_ready, 4'(1 << ids[n]));
      end
      step();
      bus.req_valid = '0;
      wait_rsp(ok, cyc);
      n_tests++;
      if (!ok || bus.rsp_p !== 6'(exps[n]) || bus.rsp_id !== 2'(ids[n])) begin
        n_fail++; $display("FAIL corner_rsp[%0d] got ok=%0d p=%0d id=%0d exp p=%0d id=%0d",
                           n, ok, bus.rsp_p, bus.rsp_id, exps[n], ids[n]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    bit seen;
    for (int i = 0; i < NREQ; i++) set_op(i, 2, i + 2);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_p !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_clear got v=%b busy=%b p=%0d exp 0 0 0",
                         bus.rsp_valid, busy, bus.rsp_p);
    end
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (bus.rsp_valid) seen = 1'b1;
      step();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_discard got rsp_valid=1 exp none");
    end
    bus.req_valid = 4'hF;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_priority got=%b exp=0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    wait_rsp(ok, cyc);
    n_tests++;
    if (!ok || bus.rsp_p !== 6'd4 || bus.rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_rsp got ok=%0d p=%0d id=%0d exp p=4 id=0",
                         ok, bus.rsp_p, bus.rsp_id);
    end
    step();
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_corner();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational 3x3 `multiplier` datapath among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, latches its operands, drives the shared multiplier, registers the product, and returns it with the requester ID on a single response channel with backpressure.

Parameters:
- NREQ, 4, number of requesters (1..8).
- W, 3, operand width; product width is 2*W.
- IDW, derived max(1, clog2(NREQ)), requester ID width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_a  input  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  packed operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot accept strobe.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IDW  index of the requester that owns rsp_p.
- rsp_p  output  2*W  product of the granted requester's A and B.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE: if any req_valid, select a winner and go to CALC; otherwise stay.
  - CALC: always go to RESP after one cycle.
  - RESP: stay while rsp_ready=0; go to IDLE on rsp_valid && rsp_ready.
- Arbitration:
  - Round-robin pointer last_id. Search starts at last_id+1 and wraps modulo NREQ.
  - The first requester found with req_valid=1 wins.
  - last_id updates to the winner in the accept cycle.
- Handshake:
  - req_ready[i] = (state==IDLE) && winner==i && !rst. It is combinational, one-hot, at most one bit set.
  - A transfer occurs when req_valid[i] && req_ready[i]. Operands are latched into op_a/op_b and the winner into id_q in that cycle.
  - req_valid may drop without acceptance; no penalty, nothing latched.
- Datapath:
  - The shared multiplier sees op_a/op_b, never the raw request ports.
  - In CALC, the multiplier output is registered into rsp_p, and id_q is copied to rsp_id.
  - The product is unsigned and full width: 2*W bits, no truncation, no overflow possible.
- Latency:
  - Accept at cycle t gives rsp_valid=1 at t+2.
  - Minimum spacing between accepts is 3 cycles (IDLE, CALC, RESP).
- Response:
  - rsp_valid=1 exactly in RESP.
  - rsp_p and rsp_id are held stable while rsp_valid && !rsp_ready.
  - A request is not accepted in the same cycle a response completes; the next accept is earliest in the following IDLE cycle.
- Reset values:
  - state=IDLE, last_id=NREQ-1 (requester 0 has first priority).
  - op_a=0, op_b=0, id_q=0, rsp_p=0, rsp_id=0, rsp_valid=0, busy=0, req_ready=0.
- Reset mid-operation: any in-flight product is discarded with no response; outputs return to reset values on the next edge.
- Boundary cases:
  - NREQ=1: no arbitration, IDW=1, rsp_id is always 0.
  - Operands 0 give rsp_p=0.
  - Maximum operands give (2^W-1)^2, e.g. 49 for W=3.

Optional Feature:
- MULT_SHARE_ARB_BYPASS_EN defined:
  - The CALC state is removed; IDLE goes directly to RESP.
  - rsp_p/rsp_id are registered in the accept cycle directly from the request operands via the multiplier.
  - Latency is 1 cycle (accept at t gives rsp_valid at t+1); minimum accept spacing is 2 cycles.
- Undefined: the 3-state behaviour above. Ports are identical in both builds.

Decomposition:
- Shared package mult_share_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_RESP=2'd2;
  - default W=3 and NREQ=4;
  - a helper function for clog2 used to derive IDW.
- Exactly one sub-module, the existing `multiplier` (A,B to P), instantiated once. The arbiter, FSM and registers stay in mult_share_arb.

Test Plan:
- Single request: req_valid=4'b0001, A0=1, B0=2, rsp_ready=1 -> req_ready[0] pulses 1 cycle; two cycles later rsp_valid=1, rsp_p=6'b000010, rsp_id=0.
- Fairness: all four valid and held, A_i=i+1, B_i=3 -> responses in order id 0,1,2,3 with products 3,6,9,12, then id 0 again.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_p and rsp_id are stable and req_ready=0 throughout; rsp_ready=1 -> back to IDLE next cycle.
- Corner values: A=7, B=7 -> rsp_p=49; A=0, B=5 -> rsp_p=0.
- Reset mid-op: rst=1 during CALC -> no rsp_valid ever for that request; after release, requester 0 wins first with all requesters valid.
- Bypass build (macro defined): single request A=3, B=5 -> rsp_valid one cycle after accept, rsp_p=15.
